// File: rtl/monishvr_fifo_if.sv
// -----------------------------------------------------------------------------
// monishvr_fifo_if
//   Pin bundle of the TinyTapeout-style user tile that hosts monishvr_fifo.
//   Signal names match the standard tile pins.
//
//   ena      tile enable (driven by the harness, ignored by the FIFO)
//   ui_in    [2]=wr_en, [3]=rd_en, [7:4]=wr_data, [1:0] reserved
//   uo_out   [0]=full, [1]=empty, [5:2]=rd_data, [6]=overflow, [7]=underflow
//   uio_in   bidirectional pin inputs (unused)
//   uio_out  bidirectional pin outputs (always 0)
//   uio_oe   bidirectional pin output enables (always 0, all inputs)
//
//   master: the harness / testbench side
//   slave : the FIFO side
// -----------------------------------------------------------------------------
interface monishvr_fifo_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena,
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ena,
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );
endinterface

// File: rtl/monishvr_fifo.sv
// -----------------------------------------------------------------------------
// monishvr_fifo
//   Synchronous single-clock FIFO (WIDTH bits x DEPTH entries) behind the
//   TinyTapeout user-tile pins.
//
//   Ports:
//     clk    rising-edge system clock
//     rst_n  asynchronous active-low reset; clears pointers, count, rd_data
//            and flags immediately
//     bus    monishvr_fifo_if.slave
//              ui_in[2]   wr_en
//              ui_in[3]   rd_en
//              ui_in[7:4] wr_data
//              uo_out[0]  full   (registered)
//              uo_out[1]  empty  (registered)
//              uo_out[5:2] rd_data (registered, one-cycle read latency)
//              uo_out[6]  overflow  (sticky, only with FIFO_ERR_FLAGS_EN)
//              uo_out[7]  underflow (sticky, only with FIFO_ERR_FLAGS_EN)
//              uio_out / uio_oe tied to 0; ena, uio_in, ui_in[1:0] ignored
//
//   Parameters:
//     DEPTH  number of entries, power of two >= 2
//     WIDTH  data width, fixed at 4 by the pin map
//
//   Optional feature macro: FIFO_ERR_FLAGS_EN
//     defined   -> sticky overflow/underflow flags on uo_out[7:6]
//     undefined -> uo_out[7:6] tied to 0, no flag logic
// -----------------------------------------------------------------------------
module monishvr_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    monishvr_fifo_if.slave   bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    // ------------------------------------------------------------------
    // Pin decode
    // ------------------------------------------------------------------
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] wr_data;

    assign wr_en   = bus.ui_in[2];
    assign rd_en   = bus.ui_in[3];
    assign wr_data = bus.ui_in[7:4];

    // Inputs that intentionally have no effect on the design.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, bus.ena, bus.uio_in, bus.ui_in[1:0]};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] rd_data;

    // ------------------------------------------------------------------
    // Accept logic
    // A write into a full FIFO is still accepted when a read frees the
    // oldest slot in the same cycle.
    // ------------------------------------------------------------------
    logic rd_acc;
    logic wr_acc;

    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    always_comb begin
        count_next = count;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // ------------------------------------------------------------------
    // Storage (contents are don't-care after reset, so no reset here)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Pointers, count, read data
    // Pointers are exactly log2(DEPTH) bits so they wrap by overflow.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            count <= count_next;
            if (wr_acc) begin
                wptr <= wptr + AW'(1);
            end
            if (rd_acc) begin
                rd_data <= mem[rptr];
                rptr    <= rptr + AW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Status flags: registered from the next count so they change on the
    // same edge as count and always equal (count == DEPTH) / (count == 0).
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    // ------------------------------------------------------------------
    // Optional sticky error flags
    // ------------------------------------------------------------------
    logic [1:0] err_bits;

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow;
    logic underflow;

    // While full the FIFO is never empty, so any rd_en is an accepted read
    // and "full with no read" reduces to !rd_acc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full && !rd_acc) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    assign err_bits = {underflow, overflow};
`else
    assign err_bits = '0;
`endif

    // ------------------------------------------------------------------
    // Output pins
    // ------------------------------------------------------------------
    assign bus.uo_out  = {err_bits, rd_data, empty, full};
    assign bus.uio_out = '0;
    assign bus.uio_oe  = '0;

endmodule

// File: tb/tb_monishvr_fifo.sv
// -----------------------------------------------------------------------------
// tb_monishvr_fifo
//   Directed and randomized stimulus for monishvr_fifo, checked against a
//   queue-based reference model of the FIFO behaviour.
// -----------------------------------------------------------------------------
module tb_monishvr_fifo;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    monishvr_fifo_if bus ();

    monishvr_fifo #(
        .DEPTH (8),
        .WIDTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [3:0] q[$];
    logic [3:0] m_rd;
    bit         m_ov;
    bit         m_uf;

    function automatic logic [7:0] model_out();
        logic [7:0] e;
        e = {2'b00, m_rd, (q.size() == 0), (q.size() == 8)};
`ifdef FIFO_ERR_FLAGS_EN
        e[6] = m_ov;
        e[7] = m_uf;
`endif
        return e;
    endfunction

    task automatic model_reset();
        q.delete();
        m_rd = 4'h0;
        m_ov = 1'b0;
        m_uf = 1'b0;
    endtask

    task automatic check(input string tag);
        logic [7:0] e;
        e = model_out();
        total++;
        assert (bus.uo_out === e) else begin
            bad++;
            $error("FAIL %s: uo_out=%h expected=%h", tag, bus.uo_out, e);
        end
        total++;
        assert ({bus.uio_out, bus.uio_oe} === 16'h0000) else begin
            bad++;
            $error("FAIL %s_uio: uio_out/uio_oe=%h expected=0000", tag, {bus.uio_out, bus.uio_oe});
        end
    endtask

    task automatic check_val(input string tag, input logic [7:0] exp);
        total++;
        assert (bus.uo_out === exp) else begin
            bad++;
            $error("FAIL %s: uo_out=%h expected=%h", tag, bus.uo_out, exp);
        end
    endtask

    // One clock cycle with the given strobes; reserved/unused pins get noise.
    task automatic step(input bit wr, input bit rd, input logic [3:0] d, input string tag);
        bit ra;
        bit wa;
        bus.ui_in  = {d, rd, wr, 2'($urandom_range(0, 3))};
        bus.uio_in = 8'($urandom);
        bus.ena    = 1'($urandom);
        @(posedge clk);
        #1;
        if (rst_n) begin
            ra = rd && (q.size() != 0);
            wa = wr && ((q.size() < 8) || ra);
            if (wr && (q.size() == 8) && !rd) m_ov = 1'b1;
            if (rd && (q.size() == 0)) m_uf = 1'b1;
            if (ra) m_rd = q.pop_front();
            if (wa) q.push_back(d);
        end
        check(tag);
    endtask

    // Assert reset between clock edges and check the outputs before any edge.
    task automatic async_reset(input string tag);
        bus.ui_in = 8'h00;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check(tag);
        check_val({tag, "_lit"}, 8'h02);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bus.ena    = 1'b1;
        bus.ui_in  = 8'h00;
        bus.uio_in = 8'h00;
        model_reset();

        // Reset held across clock edges
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'h0, "reset_hold");
        check_val("reset_lit", 8'h02);
        rst_n = 1'b1;

        // Single write then read
        step(1'b1, 1'b0, 4'hA, "wr_A");
        check_val("wr_A_lit", 8'h00);
        step(1'b0, 1'b1, 4'h0, "rd_A");
        check_val("rd_A_lit", 8'h2A);

        // Async reset with data in flight
        step(1'b1, 1'b0, 4'h5, "pre_async");
        async_reset("async_rst1");

        // Fill to full, drop a 9th write, drain in order
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 4'(i), "fill");
        check_val("full_lit", {2'b00, 4'h0, 1'b0, 1'b1});
        step(1'b1, 1'b0, 4'hF, "wr_full_drop");
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 4'h0, "drain");
        check_val("drain_last", {2'b00, 4'h7, 1'b1, 1'b0} | {bus.uo_out[7:6], 6'b0});

        // Wrap-around
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'(i + 3), "wrap_wr5");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 4'h0, "wrap_rd5");
        for (int i = 8; i < 16; i++) step(1'b1, 1'b0, 4'(i), "wrap_fill");
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 4'h0, "wrap_drain");

        // Simultaneous read/write at count=3
        step(1'b1, 1'b0, 4'h1, "rw3_pre");
        step(1'b1, 1'b0, 4'h2, "rw3_pre");
        step(1'b1, 1'b0, 4'h3, "rw3_pre");
        step(1'b1, 1'b1, 4'h4, "rw_cnt3");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'h0, "rw3_drain");

        // Simultaneous read/write at full
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 4'(i + 1), "rwf_fill");
        step(1'b1, 1'b1, 4'hC, "rw_full");
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 4'h0, "rwf_drain");

        // Simultaneous read/write at empty
        step(1'b1, 1'b1, 4'h6, "rw_empty");
        step(1'b0, 1'b1, 4'h0, "rwe_rd");

        // Error-flag scenarios (model tracks flags only when the macro is set)
        step(1'b0, 1'b1, 4'h0, "underflow");
        step(1'b0, 1'b0, 4'h0, "underflow_hold");
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 4'(i), "ovf_fill");
        step(1'b1, 1'b0, 4'h9, "overflow");
        step(1'b0, 1'b0, 4'h0, "overflow_hold");
        async_reset("flags_reset");

        // Randomized traffic: write-heavy phase then read-heavy phase
        for (int i = 0; i < 200; i++)
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0), 4'($urandom), "rand_wr_heavy");
        for (int i = 0; i < 200; i++)
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0), 4'($urandom), "rand_rd_heavy");
        for (int i = 0; i < 200; i++)
            step(1'($urandom), 1'($urandom), 4'($urandom), "rand_mixed");

        // Reset mid-operation discards data
        step(1'b1, 1'b0, 4'hE, "final_wr");
        step(1'b1, 1'b0, 4'hD, "final_wr");
        step(1'b0, 1'b1, 4'h0, "final_rd");
        async_reset("final_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
